match_stage: RTL

Exact-match lookup stage directly downstream of the parser. Accepts one parsed-header vector per transaction, selects one header word as the lookup key, and scans a programmable table for a matching valid entry. It returns the matching entry's action, or a programmable default action on miss, together with the original headers, to the action stage. Control-plane writes program table entries, key selector and default action.

---
 rtl/match_stage_pkg.sv | 36 +++
 rtl/match_stage_if.sv | 40 ++++
 rtl/match_table.sv | 44 ++++
 rtl/match_stage.sv | 104 ++++++++++
 4 files changed

// File: rtl/match_stage_pkg.sv
// Shared types, sizes and state encoding for the exact-match lookup stage.
// Every other file of the block imports this package.
package match_stage_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int NUM_HEADERS  = 8;
  localparam int NUM_ENTRIES  = 16;
  localparam int ACTION_WIDTH = 8;

  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int SEL_W  = $clog2(NUM_HEADERS);
  localparam int HDRS_W = WORD_WIDTH * NUM_HEADERS;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [WORD_WIDTH-1:0]   word_t;
  typedef logic [ACTION_WIDTH-1:0] action_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [SEL_W-1:0]        sel_t;
  typedef logic [HDRS_W-1:0]       hdrs_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_ENTRIES - 1);

  // Word k of a parsed vector lives at [k*WORD_WIDTH +: WORD_WIDTH].
  function automatic word_t hdr_word(input hdrs_t hdrs, input sel_t sel);
    return hdrs[sel*WORD_WIDTH +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/match_stage_if.sv
// Data-plane handshakes and control-plane write port of the match stage.
// "slave" is the stage itself; "master" is the parser/action/control side.
interface match_stage_if;
  import match_stage_pkg::*;

  logic    hdrs_valid_i;
  hdrs_t   hdrs_i;
  logic    hdrs_ready_o;

  logic    result_valid_o;
  logic    result_ready_i;
  logic    hit_o;
  action_t action_o;
  idx_t    hit_idx_o;
  hdrs_t   hdrs_o;

  logic    cfg_we_i;
  idx_t    cfg_addr_i;
  word_t   cfg_key_i;
  action_t cfg_action_i;
  logic    cfg_entry_valid_i;
  logic    cfg_sel_we_i;
  sel_t    cfg_sel_i;
  action_t cfg_default_i;

  modport slave (
    input  hdrs_valid_i, hdrs_i, result_ready_i,
    input  cfg_we_i, cfg_addr_i, cfg_key_i, cfg_action_i, cfg_entry_valid_i,
    input  cfg_sel_we_i, cfg_sel_i, cfg_default_i,
    output hdrs_ready_o, result_valid_o, hit_o, action_o, hit_idx_o, hdrs_o
  );

  modport master (
    output hdrs_valid_i, hdrs_i, result_ready_i,
    output cfg_we_i, cfg_addr_i, cfg_key_i, cfg_action_i, cfg_entry_valid_i,
    output cfg_sel_we_i, cfg_sel_i, cfg_default_i,
    input  hdrs_ready_o, result_valid_o, hit_o, action_o, hit_idx_o, hdrs_o
  );

endinterface

// File: rtl/match_table.sv
// Lookup table: NUM_ENTRIES x {valid, key, action}, one write port and one
// indexed combinational read port. Reset clears valid bits only.
module match_table
  import match_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    we,
  input  idx_t    waddr,
  input  word_t   wkey,
  input  action_t waction,
  input  logic    wvalid,
  input  idx_t    raddr,
  output logic    rvalid,
  output word_t   rkey,
  output action_t raction
);

  logic [NUM_ENTRIES-1:0] valid_q;
  word_t                  key_mem    [NUM_ENTRIES];
  action_t                action_mem [NUM_ENTRIES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[waddr] <= wvalid;
    end
  end

  // Key/action storage is meaningless while its valid bit is clear, so it is
  // left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      key_mem[waddr]    <= wkey;
      action_mem[waddr] <= waction;
    end
  end

  assign rvalid  = valid_q[raddr];
  assign rkey    = key_mem[raddr];
  assign raction = action_mem[raddr];

endmodule

// File: rtl/match_stage.sv
// Exact-match lookup stage: captures a parsed header vector, selects one word
// as the key and scans the table one entry per cycle, lowest index first.
module match_stage
  import match_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  match_stage_if.slave bus
);

  state_t  state;
  idx_t    scan_idx;
  word_t   key_q;
  sel_t    sel_q;
  action_t default_q;
  hdrs_t   hdrs_q;
  logic    hit_q;
  action_t action_q;
  idx_t    hit_idx_q;

  logic    rd_valid;
  word_t   rd_key;
  action_t rd_action;
  logic    entry_hit;
  logic    accept;

  match_table u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.cfg_we_i),
    .waddr   (bus.cfg_addr_i),
    .wkey    (bus.cfg_key_i),
    .waction (bus.cfg_action_i),
    .wvalid  (bus.cfg_entry_valid_i),
    .raddr   (scan_idx),
    .rvalid  (rd_valid),
    .rkey    (rd_key),
    .raction (rd_action)
  );

  // Ready is held low while reset is asserted even though the state is IDLE.
  assign bus.hdrs_ready_o = (state == IDLE) && rst;
  assign accept           = bus.hdrs_valid_i && bus.hdrs_ready_o;
  assign entry_hit        = rd_valid && (rd_key == key_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      scan_idx  <= '0;
      key_q     <= '0;
      sel_q     <= '0;
      default_q <= '0;
      hdrs_q    <= '0;
      hit_q     <= FALSE;
      action_q  <= '0;
      hit_idx_q <= '0;
    end else begin
      // Selector/default writes land regardless of state; an accept in the
      // same cycle still uses the previous selector.
      if (bus.cfg_sel_we_i) begin
        sel_q     <= bus.cfg_sel_i;
        default_q <= bus.cfg_default_i;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            hdrs_q   <= bus.hdrs_i;
            key_q    <= hdr_word(bus.hdrs_i, sel_q);
            scan_idx <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (entry_hit) begin
            hit_q     <= TRUE;
            action_q  <= rd_action;
            hit_idx_q <= scan_idx;
            state     <= DONE;
          end else if (scan_idx == LAST_IDX) begin
            hit_q     <= FALSE;
            action_q  <= default_q;
            hit_idx_q <= '0;
            state     <= DONE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.result_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result_valid_o = (state == DONE);
  assign bus.hit_o          = hit_q;
  assign bus.action_o       = action_q;
  assign bus.hit_idx_o      = hit_idx_q;
  assign bus.hdrs_o         = hdrs_q;

endmodule
